// File: rtl/prm_edge_query_seq.sv
// -----------------------------------------------------------------------------
// prm_edge_query_seq
//
// Initiator side of the per-edge obstacle checker. Streams obstacle voxel codes
// into one combinational checker, samples its edge_mask reply one cycle after
// each accepted voxel, and returns one verdict per frame. An edge is blocked if
// any voxel of the frame hits.
//
// Optional feature macro: PRM_HIT_CNT_EN
//   defined   -> res_count port present; saturating per-frame hit counter
//   undefined -> res_count port and counter removed
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   vox_valid    voxel code offered
//   vox_ready    sequencer accepts voxel (transfer = valid & ready)
//   vox_code     voxel code
//   vox_last     final voxel of frame
//   chk_code     registered code driven to checker inputs A..O
//   chk_hit      checker edge_mask (combinational from chk_code)
//   res_valid    frame verdict available
//   res_ready    consumer takes verdict (transfer = valid & ready)
//   res_blocked  1 = at least one voxel hit
//   res_count    hits in frame (PRM_HIT_CNT_EN only)
//   busy         frame in progress (state != IDLE)
// -----------------------------------------------------------------------------
module prm_edge_query_seq #(
    parameter int CODE_W = 15,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vox_valid,
    output logic              vox_ready,
    input  logic [CODE_W-1:0] vox_code,
    input  logic              vox_last,
    output logic [CODE_W-1:0] chk_code,
    input  logic              chk_hit,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_blocked,
`ifdef PRM_HIT_CNT_EN
    output logic [CNT_W-1:0]  res_count,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    logic   pend;     // chk_code holds a voxel accepted last cycle; sample now
    logic   acc;

    logic   xfer;
    logic   samp_hit;
    logic   acc_nxt;

    always_comb begin
        xfer     = vox_valid & vox_ready;
        samp_hit = pend & chk_hit;
        acc_nxt  = acc | samp_hit;
    end

`ifdef PRM_HIT_CNT_EN
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Saturate instead of wrapping so a large frame never reports few hits.
    always_comb begin
        cnt_nxt = cnt;
        if (samp_hit && (cnt != '1))
            cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            res_count <= '0;
        end else if (state == RESP && res_ready) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (state == FLUSH)
                res_count <= cnt_nxt;
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            vox_ready   <= 1'b1;
            chk_code    <= '0;
            pend        <= 1'b0;
            acc         <= 1'b0;
            res_valid   <= 1'b0;
            res_blocked <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pend <= xfer;
            if (xfer)
                chk_code <= vox_code;
            acc <= acc_nxt;

            case (state)
                IDLE: begin
                    if (xfer) begin
                        busy <= 1'b1;
                        if (vox_last) begin
                            state     <= FLUSH;
                            vox_ready <= 1'b0;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (xfer && vox_last) begin
                        state     <= FLUSH;
                        vox_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    // Final voxel's sample lands this edge; fold it into the verdict.
                    state       <= RESP;
                    res_valid   <= 1'b1;
                    res_blocked <= acc_nxt;
                end
                RESP: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        vox_ready <= 1'b1;
                        busy      <= 1'b0;
                        acc       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prm_edge_query_seq.sv
module tb_prm_edge_query_seq;

    localparam int CODE_W = 15;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              vox_valid;
    logic [CODE_W-1:0] vox_code;
    logic              vox_last;
    logic              res_ready;

    logic              vox_ready,   vox_ready2;
    logic [CODE_W-1:0] chk_code,    chk_code2;
    logic              chk_hit,     chk_hit2;
    logic              res_valid,   res_valid2;
    logic              res_blocked, res_blocked2;
    logic              busy,        busy2;
    logic [CNT_W-1:0]  res_count;
    logic [1:0]        res_count2;

    // Checker model: hit when voxel has both O (bit 14) and J (bit 9) set.
    assign chk_hit  = chk_code[14]  & chk_code[9];
    assign chk_hit2 = chk_code2[14] & chk_code2[9];

    always #5 clk = ~clk;

    prm_edge_query_seq #(.CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .vox_valid(vox_valid), .vox_ready(vox_ready),
        .vox_code(vox_code), .vox_last(vox_last),
        .chk_code(chk_code), .chk_hit(chk_hit),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_blocked(res_blocked),
`ifdef PRM_HIT_CNT_EN
        .res_count(res_count),
`endif
        .busy(busy)
    );

    // Narrow-counter instance sharing the voxel stream, for saturation.
    prm_edge_query_seq #(.CODE_W(CODE_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .vox_valid(vox_valid), .vox_ready(vox_ready2),
        .vox_code(vox_code), .vox_last(vox_last),
        .chk_code(chk_code2), .chk_hit(chk_hit2),
        .res_valid(res_valid2), .res_ready(res_ready),
        .res_blocked(res_blocked2),
`ifdef PRM_HIT_CNT_EN
        .res_count(res_count2),
`endif
        .busy(busy2)
    );

`ifndef PRM_HIT_CNT_EN
    assign res_count  = '0;
    assign res_count2 = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int                n;
        logic [CODE_W-1:0] codes [5];
        bit                bubbles;
        logic              exp_blocked;
        int                exp_count;
    } frame_t;

    // Sends one frame, checks first-sample timing, verdict latency and values.
    // If hold_cycles > 0, res_ready is held low that many cycles first.
    task automatic run_frame(input frame_t f, input int hold_cycles);
        for (int i = 0; i < f.n; i++) begin
            if (f.bubbles && i > 0) begin
                vox_valid = 1'b0;
                tick();
                check("bubble_busy", busy, 1'b1);
            end
            vox_valid = 1'b1;
            vox_code  = f.codes[i];
            vox_last  = (i == f.n - 1);
            check("vox_ready_in_frame", vox_ready, 1'b1);
            tick();
        end
        vox_valid = 1'b0;
        vox_last  = 1'b0;
        // cycle t+1
        check("chk_code_last", chk_code, f.codes[f.n-1]);
        check("res_valid_t1", res_valid, 1'b0);
        check("vox_ready_flush", vox_ready, 1'b0);
        tick();
        // cycle t+2
        check("res_valid_t2", res_valid, 1'b1);
        check("res_blocked", res_blocked, f.exp_blocked);
        check("res_blocked2", res_blocked2, f.exp_blocked);
`ifdef PRM_HIT_CNT_EN
        check("res_count", res_count, f.exp_count);
        check("res_count_sat", res_count2, (f.exp_count > 3) ? 3 : f.exp_count);
`endif
        for (int h = 0; h < hold_cycles; h++) begin
            tick();
            check("hold_valid", res_valid, 1'b1);
            check("hold_blocked", res_blocked, f.exp_blocked);
            check("hold_vox_ready", vox_ready, 1'b0);
`ifdef PRM_HIT_CNT_EN
            check("hold_count", res_count, f.exp_count);
`endif
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("post_res_valid", res_valid, 1'b0);
        check("post_vox_ready", vox_ready, 1'b1);
        check("post_busy", busy, 1'b0);
    endtask

    frame_t vec [7];
    frame_t fr;

    initial begin
        rst       = 1'b1;
        vox_valid = 1'b0;
        vox_code  = '0;
        vox_last  = 1'b0;
        res_ready = 1'b0;

        vec[0] = '{1, '{15'h4200, 15'h0, 15'h0, 15'h0, 15'h0}, 1'b0, 1'b1, 1};
        vec[1] = '{3, '{15'h0000, 15'h0000, 15'h0000, 15'h0, 15'h0}, 1'b0, 1'b0, 0};
        vec[2] = '{4, '{15'h0000, 15'h4200, 15'h0000, 15'h4200, 15'h0}, 1'b1, 1'b1, 2};
        vec[3] = '{3, '{15'h4200, 15'h0000, 15'h0000, 15'h0, 15'h0}, 1'b0, 1'b1, 1};
        vec[4] = '{3, '{15'h7FFF, 15'h4000, 15'h0200, 15'h0, 15'h0}, 1'b1, 1'b1, 1};
        vec[5] = '{2, '{15'h0200, 15'h4000, 15'h0, 15'h0, 15'h0}, 1'b0, 1'b0, 0};
        vec[6] = '{5, '{15'h4200, 15'h4200, 15'h4200, 15'h4200, 15'h4200}, 1'b0, 1'b1, 5};

        tick();
        tick();
        rst = 1'b0;
        // reset state
        check("rst_vox_ready", vox_ready, 1'b1);
        check("rst_chk_code", chk_code, 0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_blocked", res_blocked, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_res_count", res_count, 0);

        foreach (vec[k]) run_frame(vec[k], 0);

        // Consumer back-pressure: verdict held 5 cycles.
        run_frame(vec[0], 5);

        // Reset after two voxels of a frame discards it.
        vox_valid = 1'b1;
        vox_code  = 15'h4200;
        vox_last  = 1'b0;
        tick();
        check("midframe_busy", busy, 1'b1);
        tick();
        vox_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_vox_ready", vox_ready, 1'b1);
        check("mrst_chk_code", chk_code, 0);
        check("mrst_res_valid", res_valid, 1'b0);
        check("mrst_res_blocked", res_blocked, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_res_count", res_count, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mrst_no_verdict", res_valid, 1'b0);
        end
        // Next frame must not inherit the discarded hits.
        fr = vec[1];
        run_frame(fr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
